// File: rtl/tlp_arbiter_router.sv
// Strict-priority arbiter from four show-ahead input FIFOs to four class-routed output FIFOs,
// plus the RESET/INIT/IDLE/ACTIVE control FSM and threshold registers; pop in N, push in N+1.
module tlp_arbiter_router #(
  parameter int DATA_W    = 12,
  parameter int CLASS_LSB = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [2:0]        Umbral_bajo,
  input  logic [2:0]        Umbral_alto,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [3:0]        empty_in,
  input  logic [3:0]        almost_full_out,
  output logic [3:0]        pop_in,
  output logic [3:0]        push_out,
  output logic [DATA_W-1:0] data_out,
  output logic [2:0]        umbral_bajo_q,
  output logic [2:0]        umbral_alto_q,
  output logic [3:0]        state,
  output logic              idle
);

  typedef enum logic [3:0] {
    S_RESET  = 4'b0001,
    S_INIT   = 4'b0010,
    S_IDLE   = 4'b0100,
    S_ACTIVE = 4'b1000
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_push;
  logic [DATA_W-1:0] r_data;
  logic [2:0]        r_bajo;
  logic [2:0]        r_alto;

  logic [DATA_W-1:0] w_word [4];
  logic [1:0]        w_dest [4];
  logic [3:0]        w_elig;
  logic              w_grant;
  logic [1:0]        w_sel;

  assign w_word[0] = data_in0;
  assign w_word[1] = data_in1;
  assign w_word[2] = data_in2;
  assign w_word[3] = data_in3;

  // A blocked high-priority input is skipped rather than stalling the others.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_dest[i] = w_word[i][CLASS_LSB+1:CLASS_LSB];
      w_elig[i] = ~empty_in[i] & ~almost_full_out[w_dest[i]];
    end
  end

  always_comb begin
    w_grant = 1'b0;
    w_sel   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_grant = 1'b1;
        w_sel   = 2'(i);
      end
    end
    if (r_state != S_ACTIVE || reset) begin
      w_grant = 1'b0;
    end
  end

  assign pop_in = w_grant ? (4'b0001 << w_sel) : 4'b0000;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RESET:  w_next = S_INIT;
      S_INIT:   if (!init) w_next = S_IDLE;
      S_IDLE: begin
        if (init)                  w_next = S_INIT;
        else if (empty_in != 4'hF) w_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (init)                                 w_next = S_INIT;
        else if (empty_in == 4'hF && !w_grant)    w_next = S_IDLE;
      end
      default:  w_next = S_RESET;
    endcase
  end

  // The push for a grant taken on the edge into INIT still lands, so nothing is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RESET;
      r_push  <= 4'b0000;
      r_data  <= '0;
      r_bajo  <= 3'd1;
      r_alto  <= 3'd6;
    end else begin
      r_state <= w_next;
      r_push  <= w_grant ? (4'b0001 << w_dest[w_sel]) : 4'b0000;
      if (w_grant) begin
        r_data <= w_word[w_sel];
      end
      if (r_state == S_INIT) begin
        r_bajo <= Umbral_bajo;
        r_alto <= Umbral_alto;
      end
    end
  end

  assign push_out      = r_push;
  assign data_out      = r_data;
  assign umbral_bajo_q = r_bajo;
  assign umbral_alto_q = r_alto;
  assign state         = r_state;
  assign idle          = (r_state == S_IDLE) && (empty_in == 4'hF);

endmodule

// File: doc/tlp_arbiter_router.md
# tlp_arbiter_router

Routes the transaction layer's input side to its output side. It arbitrates among the four input FIFOs with strict priority, with FIFO 0 highest. Each granted word is routed to one of four output FIFOs, selected by a 2-bit class field inside the word. The block also owns the main control FSM (RESET/INIT/IDLE/ACTIVE) and the threshold registers that feed every FIFO's almost-full/almost-empty logic.

## Interface
Parameters:
- DATA_W, 12: word width.
- CLASS_LSB, 8: LSB of the 2-bit destination field, `data[CLASS_LSB+1:CLASS_LSB]`.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- init  input  1  holds/enters INIT state while high.
- Umbral_bajo  input  3  low threshold, sampled in INIT.
- Umbral_alto  input  3  high threshold, sampled in INIT.
- data_in0..data_in3  input  DATA_W each  head word of input FIFO i (show-ahead).
- empty_in  input  4  bit i = input FIFO i empty.
- almost_full_out  input  4  bit d = output FIFO d almost full.
- pop_in  output  4  bit i = consume head of input FIFO i this cycle (combinational).
- push_out  output  4  bit d = write data_out into output FIFO d (registered).
- data_out  output  DATA_W  registered routed word.
- umbral_bajo_q  output  3  registered low threshold to all FIFOs.
- umbral_alto_q  output  3  registered high threshold to all FIFOs.
- state  output  4  one-hot FSM state: RESET=0001, INIT=0010, IDLE=0100, ACTIVE=1000.
- idle  output  1  high in IDLE with all inputs empty.

## Operation
FSM:
- reset=1 forces RESET next edge, from any state.
- RESET exits to INIT on the first cycle with reset=0.
- INIT stays while init=1 and goes to IDLE when init=0.
- In INIT, umbral_bajo_q/umbral_alto_q load Umbral_bajo/Umbral_alto every cycle; thresholds are frozen outside INIT.
- IDLE goes to ACTIVE when any `~empty_in[i]`.
- ACTIVE goes to IDLE when `empty_in==4'hF` and no grant this cycle.
- init=1 in IDLE or ACTIVE goes to INIT.

Arbitration:
- Combinational, evaluated only in ACTIVE.
- Input i is eligible when `~empty_in[i] & ~almost_full_out[dest_i]`, with `dest_i = data_in_i[CLASS_LSB+1:CLASS_LSB]`.
- Grant goes to the lowest-index eligible input.
- An ineligible higher-priority input is skipped, not waited on.
- At most one pop_in bit is set per cycle; pop_in is 0 outside ACTIVE and during reset.

Routing:
- On a grant, data_out is loaded with the granted word on the next edge.
- On that same edge, push_out is loaded with `one_hot(dest)`; otherwise push_out is 0.
- data_out holds its last value when there is no push.
- A push already in flight on entry to INIT still completes the following cycle; no word is lost or duplicated.

Backpressure margin:
- almost_full_out is one cycle stale relative to the in-flight push.
- Integrators must keep `Umbral_alto <= depth-2`.

Reset values:
- state=RESET, push_out=0, data_out=0, pop_in=0, idle=0.
- umbral_bajo_q=3'd1, umbral_alto_q=3'd6.

## Timing
- Latency: pop_in[i] in cycle N, then push_out[d]/data_out valid in cycle N+1.
- Throughput: 1 word/cycle sustained.
- FSM response:
  - ACTIVE is reached the cycle after the first non-empty input is seen in IDLE.
  - The first pop is in the first ACTIVE cycle.
- almost_full_out[d] rising in cycle N blocks grants to d starting in cycle N.
- Simultaneous reset and init: reset wins.
- Reset mid-transfer: an in-flight push is cancelled, and push_out=0 on the cycle after reset.
- A class field of any value is valid; all 4 destinations are reachable from every input.

## Test plan
- **Reset/init/thresholds:**
  - Stimulus: reset=1 for 2 cycles, then reset=0 with init=1; drive Umbral 0/7, then 1/6; then init=0.
  - Required: state goes 0001 → 0010 → 0100; umbral_*_q end at 1/6; they stay unchanged when Umbral inputs are changed in IDLE.
- **Priority:**
  - Stimulus: all four inputs non-empty with heads 0x001, 0x102, 0x204, 0x308.
  - Required: pops in order 0, 1, 2, 3; data_out sequence 0x001 → push_out 0001, 0x102 → 0010, 0x204 → 0100, 0x308 → 1000; each push exactly one cycle after its pop.
- **Skip on almost-full:**
  - Stimulus: almost_full_out=0001; input 0 head 0x005, input 1 head 0x106.
  - Required: input 1 is granted, 0x106 goes to output 1, and input 0 is not popped; clearing almost_full_out then grants input 0 next cycle.
- **16-combination sweep:**
  - Stimulus: each input carries 4 words, one per class.
  - Required: all 16 words arrive exactly once at the matching output; return to IDLE once drained.
- **Mid-stream init:**
  - Stimulus: raise init while pop_in=0010.
  - Required: the corresponding push_out=0010 still occurs next cycle; no pops while in INIT.
- **Mid-stream reset:**
  - Stimulus: assert reset on a pop cycle.
  - Required: push_out=0 and state=RESET next cycle.
